// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC-driven instruction fetch over a req/ack memory port with misalign and timeout errors
// Ports: clk, reset_n (sync, active-low); pc_in/fetch_go from the core;
//   imem_req/imem_addr/imem_ack/imem_rdata to instruction memory;
//   instr/instr_valid/busy/fetch_err/err_clr toward the core; buf_flush drops the fetch buffer.
// Optional: define FETCH_BUF_EN for a one-entry fetch buffer (tag + data + valid).
module instr_fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fetch_go,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              busy,
  output logic              fetch_err,
  input  logic              err_clr,
  input  logic              buf_flush
);
  typedef enum logic {IDLE, REQ} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t     state;
  logic [7:0] cnt;
  logic       aligned;
  assign aligned = pc_in[1:0] == 2'b00;
  assign busy = state == REQ;
`ifdef FETCH_BUF_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_tag;
  logic [DATA_W-1:0] buf_data;
  logic              hit;
  assign hit = buf_valid && buf_tag == pc_in;
`else
  logic unused_flush;
  assign unused_flush = buf_flush;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      cnt         <= '0;
`ifdef FETCH_BUF_EN
      buf_valid   <= 1'b0;
      buf_tag     <= '0;
      buf_data    <= '0;
`endif
    end else begin
      instr_valid <= 1'b0;
      // a new error later in this block overrides the clear
      if (err_clr) fetch_err <= 1'b0;
      if (state == IDLE) begin
        if (fetch_go && !aligned) fetch_err <= 1'b1;
        else if (fetch_go) begin
`ifdef FETCH_BUF_EN
          if (hit) begin
            instr       <= buf_data;
            instr_valid <= 1'b1;
          end else begin
`endif
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_in;
            cnt       <= '0;
`ifdef FETCH_BUF_EN
          end
`endif
        end
      end else if (imem_ack) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
        imem_req    <= 1'b0;
        state       <= IDLE;
`ifdef FETCH_BUF_EN
        buf_valid   <= 1'b1;
        buf_tag     <= imem_addr;
        buf_data    <= imem_rdata;
`endif
      end else if (cnt == LAST) begin
        fetch_err   <= 1'b1;
        instr       <= '0;
        instr_valid <= 1'b1;
        imem_req    <= 1'b0;
        state       <= IDLE;
      end else cnt <= cnt + 1'b1;
`ifdef FETCH_BUF_EN
      // flush is last so it beats a same-cycle fill
      if (buf_flush) buf_valid <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus, per-cycle model comparison and literal checks for instr_fetch_unit
module tb_instr_fetch_unit;
  localparam int TO = 4;
`ifdef FETCH_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  logic        clk = 1'b0, reset_n = 1'b0, fetch_go = 1'b0, imem_ack = 1'b0;
  logic        err_clr = 1'b0, buf_flush = 1'b0;
  logic [31:0] pc_in = '0, imem_rdata = '0;
  logic        imem_req, instr_valid, busy, fetch_err;
  logic [31:0] imem_addr, instr;
  int n_cmp = 0, n_bad = 0;

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .fetch_go(fetch_go),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .busy(busy), .fetch_err(fetch_err),
    .err_clr(err_clr), .buf_flush(buf_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: a fetch is either pending (with its address and
  // number of memory cycles spent) or not; outputs follow from that.
  bit          m_live = 0, m_pend = 0, m_valid = 0, m_err = 0, m_bv = 0;
  logic [31:0] m_addr = '0, m_instr = '0, m_btag = '0, m_bdata = '0;
  int          m_spent = 0;
  always @(posedge clk) begin
    if (!reset_n) begin
      m_live = 1; m_pend = 0; m_valid = 0; m_err = 0; m_bv = 0;
      m_addr = '0; m_instr = '0; m_spent = 0;
    end else if (m_live) begin
      m_valid = 0;
      if (err_clr) m_err = 0;
      if (m_pend) begin
        if (imem_ack) begin
          m_instr = imem_rdata; m_valid = 1; m_pend = 0;
          if (BUF) begin m_bv = 1; m_btag = m_addr; m_bdata = imem_rdata; end
        end else if (m_spent == TO) begin
          m_err = 1; m_instr = '0; m_valid = 1; m_pend = 0;
        end else m_spent++;
      end else if (fetch_go) begin
        if (pc_in % 4 != 0) m_err = 1;
        else if (m_bv && m_btag == pc_in) begin m_instr = m_bdata; m_valid = 1; end
        else begin m_pend = 1; m_addr = pc_in; m_spent = 1; end
      end
      if (buf_flush) m_bv = 0;
    end
  end

  always @(negedge clk) if (m_live) begin
    chk("req", 32'(imem_req), 32'(m_pend));
    chk("busy", 32'(busy), 32'(m_pend));
    chk("addr", imem_addr, m_addr);
    chk("instr", instr, m_instr);
    chk("valid", 32'(instr_valid), 32'(m_valid));
    chk("err", 32'(fetch_err), 32'(m_err));
    chk("valid_while_busy", 32'(instr_valid & busy), 32'd0);
  end

  initial begin
    int reqc, pulses;
    // reset
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_err", 32'(fetch_err), 0);
    chk("rst_addr", imem_addr, 0);
    // normal fetch, ack in third request cycle
    pc_in = 32'h150; fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    chk("t2_req1", 32'(imem_req), 1); chk("t2_addr1", imem_addr, 32'h150);
    tick();
    chk("t2_addr2", imem_addr, 32'h150); chk("t2_valid2", 32'(instr_valid), 0);
    tick();
    chk("t2_addr3", imem_addr, 32'h150); chk("t2_busy3", 32'(busy), 1);
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005; tick(); imem_ack = 1'b0; imem_rdata = '0;
    chk("t2_valid", 32'(instr_valid), 1); chk("t2_instr", instr, 32'h2008_0005);
    chk("t2_req_done", 32'(imem_req), 0);
    tick();
    chk("t2_pulse_once", 32'(instr_valid), 0);
    // misaligned PC, then clear
    pc_in = 32'h152; fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    chk("t3_err", 32'(fetch_err), 1); chk("t3_req", 32'(imem_req), 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t3_clr", 32'(fetch_err), 0);
    // set and clear together: set wins
    fetch_go = 1'b1; err_clr = 1'b1; tick(); fetch_go = 1'b0; err_clr = 1'b0;
    chk("set_wins", 32'(fetch_err), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    // timeout
    pc_in = 32'h200; fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    reqc = 0; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req) reqc++;
      if (instr_valid) pulses++;
      tick();
    end
    chk("t4_req_cycles", 32'(reqc), 4); chk("t4_pulses", 32'(pulses), 1);
    chk("t4_err", 32'(fetch_err), 1); chk("t4_instr", instr, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    // ack in the timeout cycle wins
    pc_in = 32'h204; fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    tick(); tick(); tick();
    imem_ack = 1'b1; imem_rdata = 32'hA5A5_0001; tick(); imem_ack = 1'b0;
    chk("late_ack_valid", 32'(instr_valid), 1); chk("late_ack_err", 32'(fetch_err), 0);
    chk("late_ack_instr", instr, 32'hA5A5_0001);
    // minimum latency
    pc_in = 32'h208; fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0000_1234; tick(); imem_ack = 1'b0;
    chk("minlat_valid", 32'(instr_valid), 1); chk("minlat_instr", instr, 32'h1234);
    // fetch_go while busy ignored
    pc_in = 32'h20C; fetch_go = 1'b1; tick();
    pc_in = 32'h300; tick();
    imem_ack = 1'b1; imem_rdata = 32'h0000_5678; tick(); imem_ack = 1'b0; fetch_go = 1'b0;
    chk("busy_go_addr", imem_addr, 32'h20C); chk("busy_go_instr", instr, 32'h5678);
    tick();
    chk("busy_go_idle", 32'(busy), 0);
    // reset mid-request, late ack ignored
    pc_in = 32'h300; fetch_go = 1'b1; tick(); fetch_go = 1'b0; tick();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("t5_req", 32'(imem_req), 0); chk("t5_busy", 32'(busy), 0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_ack = 1'b0;
    chk("t5_valid", 32'(instr_valid), 0); chk("t5_instr", instr, 0);
    // repeat fetch: buffer hit when enabled, memory otherwise
    pc_in = 32'h150; fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005; tick(); imem_ack = 1'b0;
    chk("t6_first", instr, 32'h2008_0005);
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
`ifdef FETCH_BUF_EN
    chk("t6_hit_req", 32'(imem_req), 0); chk("t6_hit_valid", 32'(instr_valid), 1);
    chk("t6_hit_instr", instr, 32'h2008_0005);
`else
    chk("t6_nobuf_req", 32'(imem_req), 1);
    imem_ack = 1'b1; tick(); imem_ack = 1'b0;
`endif
    buf_flush = 1'b1; tick(); buf_flush = 1'b0;
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    chk("t6_flush_req", 32'(imem_req), 1);
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222; tick(); imem_ack = 1'b0;
    chk("t6_flush_instr", instr, 32'h1111_2222);
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
